// File: rtl/int_ctrl.sv
// ----------------------------------------------------------------------------
// int_ctrl : interrupt receiver and coprocessor-0 register file.
//
// Hardware interrupt lines from the timers and the external pin are sampled
// into Cause.IP, masked by SR.IM and gated by SR.IE / SR.EXL to form a single
// interrupt request to the pipeline. Exception entry saves the victim PC into
// EPC and sets EXL; eret clears EXL. SR, Cause, EPC and PRId are accessible
// through the coprocessor move-to / move-from port.
//
// Parameters:
//   PRID      constant read back from register 15 (PRId)
//   IM_RESET  reset value of SR.IM[15:10]
//
// Optional feature (compile-time macro INT_CTRL_EDGE_LATCH_EN):
//   defined   - IP[12] (external pin) is a sticky edge latch, cleared by a
//               move-to Cause with wd[12] = 0; a set in the same cycle wins.
//   undefined - IP[12] follows the synchronized pin level; Cause writes are
//               ignored.
//
// Ports:
//   clk      in   system clock, rising-edge
//   reset    in   asynchronous active-low reset
//   hw_int   in   [5:0] interrupt lines {3'b0, ext pin, timer1, timer0}
//                 bit 2 is asynchronous and is synchronized here
//   sel      in   [4:0] register number: 12 SR, 13 Cause, 14 EPC, 15 PRId
//   we       in   move-to write strobe
//   wd       in   [31:0] move-to write data
//   rd       out  [31:0] move-from read data (combinational)
//   exl_set  in   exception entry this cycle
//   epc_in   in   [31:0] victim PC captured on exl_set
//   bd_in    in   victim sits in a branch delay slot
//   exl_clr  in   eret retiring this cycle
//   int_req  out  interrupt request to the pipeline
//   epc_out  out  [31:0] current EPC (eret target)
// ----------------------------------------------------------------------------
module int_ctrl #(
  parameter logic [31:0] PRID     = 32'h0C07_0001,
  parameter logic [5:0]  IM_RESET = 6'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hw_int,
  input  logic [4:0]  sel,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  input  logic        exl_set,
  input  logic [31:0] epc_in,
  input  logic        bd_in,
  input  logic        exl_clr,
  output logic        int_req,
  output logic [31:0] epc_out
);

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;

  // External pin synchronizer
  logic        sync1_r;
  logic        sync2_r;
`ifdef INT_CTRL_EDGE_LATCH_EN
  logic        sync3_r;
  logic        pin_rise_s;
  logic        cause_clr_s;
`endif

  // Architectural state
  logic [5:0]  im_r;
  logic        exl_r;
  logic        ie_r;
  logic [5:0]  ip_r;
  logic        bd_r;
  logic [4:0]  exc_code_r;
  logic [29:0] epc_r;

  // Next-state values
  logic [5:0]  im_next_s;
  logic        exl_next_s;
  logic        ie_next_s;
  logic [5:0]  ip_next_s;
  logic        bd_next_s;
  logic [4:0]  exc_code_next_s;
  logic [29:0] epc_next_s;

  logic        sr_we_s;
  logic        epc_we_s;

  // The low PC bits are always discarded; the word-aligned EPC keeps [31:2].
  logic        epc_in_unused_s;
  assign epc_in_unused_s = ^epc_in[1:0];

  assign sr_we_s  = we && (sel == SEL_SR);
  assign epc_we_s = we && (sel == SEL_EPC);

  // Two-flop synchronizer for the asynchronous external pin
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= hw_int[2];
      sync2_r <= sync1_r;
    end
  end

`ifdef INT_CTRL_EDGE_LATCH_EN
  // Delayed copy of the synchronized pin for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync3_r <= 1'b0;
    end else begin
      sync3_r <= sync2_r;
    end
  end

  assign pin_rise_s  = sync2_r & ~sync3_r;
  assign cause_clr_s = we && (sel == SEL_CAUSE) && !wd[12];
`endif

  // Pending-interrupt sampling
  always_comb begin
    ip_next_s = {hw_int[5:3], sync2_r, hw_int[1:0]};
`ifdef INT_CTRL_EDGE_LATCH_EN
    // Sticky external-pin bit: a new edge beats a simultaneous clear.
    if (pin_rise_s) begin
      ip_next_s[2] = 1'b1;
    end else if (cause_clr_s) begin
      ip_next_s[2] = 1'b0;
    end else begin
      ip_next_s[2] = ip_r[2];
    end
`endif
  end

  // SR next state: IM/IE follow a move-to; EXL priority is set > clr > write
  always_comb begin
    im_next_s  = im_r;
    ie_next_s  = ie_r;
    exl_next_s = exl_r;
    if (sr_we_s) begin
      im_next_s = wd[15:10];
      ie_next_s = wd[0];
    end else begin
      im_next_s = im_r;
      ie_next_s = ie_r;
    end
    if (exl_set) begin
      exl_next_s = 1'b1;
    end else if (exl_clr) begin
      exl_next_s = 1'b0;
    end else if (sr_we_s) begin
      exl_next_s = wd[1];
    end else begin
      exl_next_s = exl_r;
    end
  end

  // EPC / BD / ExcCode next state: exception entry beats a move-to EPC
  always_comb begin
    epc_next_s      = epc_r;
    bd_next_s       = bd_r;
    exc_code_next_s = exc_code_r;
    if (exl_set) begin
      epc_next_s      = epc_in[31:2];
      bd_next_s       = bd_in;
      exc_code_next_s = 5'd0;
    end else if (epc_we_s) begin
      epc_next_s      = wd[31:2];
    end else begin
      epc_next_s      = epc_r;
    end
  end

  // Architectural register update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_r       <= IM_RESET;
      exl_r      <= 1'b0;
      ie_r       <= 1'b0;
      ip_r       <= 6'h00;
      bd_r       <= 1'b0;
      exc_code_r <= 5'd0;
      epc_r      <= 30'd0;
    end else begin
      im_r       <= im_next_s;
      exl_r      <= exl_next_s;
      ie_r       <= ie_next_s;
      ip_r       <= ip_next_s;
      bd_r       <= bd_next_s;
      exc_code_r <= exc_code_next_s;
      epc_r      <= epc_next_s;
    end
  end

  // Request is purely a function of registered state so reset kills it at once
  assign int_req = ie_r & ~exl_r & (|(ip_r & im_r));
  assign epc_out = {epc_r, 2'b00};

  // Move-from read mux
  always_comb begin
    rd = 32'h0000_0000;
    case (sel)
      SEL_SR:    rd = {16'h0000, im_r, 8'h00, exl_r, ie_r};
      SEL_CAUSE: rd = {bd_r, 15'h0000, ip_r, 3'b000, exc_code_r, 2'b00};
      SEL_EPC:   rd = {epc_r, 2'b00};
      SEL_PRID:  rd = PRID;
      default:   rd = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

  localparam logic [31:0] PRID     = 32'h0C07_0001;
  localparam logic [5:0]  IM_RESET = 6'h00;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hw_int;
  logic [4:0]  sel;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        exl_set;
  logic [31:0] epc_in;
  logic        bd_in;
  logic        exl_clr;
  logic        int_req;
  logic [31:0] epc_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  int_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .hw_int  (hw_int),
    .sel     (sel),
    .we      (we),
    .wd      (wd),
    .rd      (rd),
    .exl_set (exl_set),
    .epc_in  (epc_in),
    .bd_in   (bd_in),
    .exl_clr (exl_clr),
    .int_req (int_req),
    .epc_out (epc_out)
  );

  always #5 clk = ~clk;

  // Reference model: architectural fields plus a history of the hw_int
  // values seen at the last four rising edges (h0 = most recent).
  logic [5:0]  m_im;
  logic        m_exl, m_ie, m_bd;
  logic [5:0]  m_ip;
  logic [31:0] m_epc;
  logic        m_sticky;
  logic [5:0]  h0, h1, h2, h3;

  task automatic model_reset();
    m_im = IM_RESET; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0;
    m_ip = 6'h00; m_epc = 32'h0; m_sticky = 1'b0;
    h0 = 6'h00; h1 = 6'h00; h2 = 6'h00; h3 = 6'h00;
  endtask

  function automatic logic exp_req();
    return m_ie & ~m_exl & (|(m_ip & m_im));
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] s);
    case (s)
      5'd12:   return {16'h0, m_im, 8'h0, m_exl, m_ie};
      5'd13:   return {m_bd, 15'h0, m_ip, 10'h0};
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model with the inputs currently held, then clock the DUT.
  task automatic tick();
    logic clr;
    h3 = h2; h2 = h1; h1 = h0; h0 = hw_int;
    // The external pin is seen two edges after it was sampled.
    m_ip = {h0[5:3], h2[2], h0[1:0]};
`ifdef INT_CTRL_EDGE_LATCH_EN
    clr = we && (sel == 5'd13) && !wd[12];
    m_sticky = (h2[2] & ~h3[2]) | (m_sticky & ~clr);
    m_ip[2] = m_sticky;
`else
    clr = 1'b0;
    m_sticky = clr;
`endif
    if (exl_set)                        m_exl = 1'b1;
    else if (exl_clr)                   m_exl = 1'b0;
    else if (we && sel == 5'd12)        m_exl = wd[1];
    if (we && sel == 5'd12) begin
      m_im = wd[15:10];
      m_ie = wd[0];
    end
    if (exl_set) begin
      m_epc = {epc_in[31:2], 2'b00};
      m_bd  = bd_in;
    end else if (we && sel == 5'd14) begin
      m_epc = {wd[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wd = 32'h0; exl_set = 1'b0; exl_clr = 1'b0;
    epc_in = 32'h0; bd_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; hw_int = 6'h00; sel = 5'd0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    for (int s = 12; s <= 16; s++) begin
      sel = 5'(s);
      #1;
      total_cnt++;
      if (rd !== exp_rd(sel)) $display("FAIL reset_rd sel=%0d: got %h expected %h", s, rd, exp_rd(sel));
      else pass_cnt++;
    end
    total_cnt++;
    if (int_req !== 1'b0) $display("FAIL reset_int_req: got %b expected 0", int_req);
    else pass_cnt++;
  endtask

  task automatic test_timer();
    we = 1'b1; sel = 5'd12; wd = 32'h0000_0401;
    tick();
    we = 1'b0; hw_int = 6'h01;
    #1;
    total_cnt++;
    if (int_req !== 1'b0) $display("FAIL timer_latency_early: got %b expected 0", int_req);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (int_req !== 1'b1) $display("FAIL timer_req: got %b expected 1", int_req);
    else pass_cnt++;
    we = 1'b1; wd = 32'h0000_0400;
    tick();
    we = 1'b0;
    total_cnt++;
    if (int_req !== 1'b0) $display("FAIL timer_ie_off: got %b expected 0", int_req);
    else pass_cnt++;
  endtask

  task automatic test_entry_eret();
    we = 1'b1; sel = 5'd12; wd = 32'h0000_0401;
    tick();
    we = 1'b0;
    total_cnt++;
    if (int_req !== 1'b1) $display("FAIL entry_pre_req: got %b expected 1", int_req);
    else pass_cnt++;
    exl_set = 1'b1; epc_in = 32'h0000_3017; bd_in = 1'b1;
    tick();
    idle_inputs();
    total_cnt++;
    if (epc_out !== 32'h0000_3014) $display("FAIL entry_epc: got %h expected %h", epc_out, 32'h0000_3014);
    else pass_cnt++;
    sel = 5'd13; #1;
    total_cnt++;
    if (rd[31] !== 1'b1) $display("FAIL entry_bd: got %b expected 1", rd[31]);
    else pass_cnt++;
    sel = 5'd12; #1;
    total_cnt++;
    if (rd[1] !== 1'b1) $display("FAIL entry_exl: got %b expected 1", rd[1]);
    else pass_cnt++;
    total_cnt++;
    if (int_req !== 1'b0) $display("FAIL entry_masked: got %b expected 0", int_req);
    else pass_cnt++;
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    total_cnt++;
    if (int_req !== 1'b1) $display("FAIL eret_req: got %b expected 1", int_req);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    exl_set = 1'b1; epc_in = 32'h0000_3000;
    we = 1'b1; sel = 5'd14; wd = 32'h0000_4000;
    tick();
    idle_inputs();
    total_cnt++;
    if (epc_out !== 32'h0000_3000) $display("FAIL prio_epc: got %h expected %h", epc_out, 32'h0000_3000);
    else pass_cnt++;
    exl_clr = 1'b1; we = 1'b1; sel = 5'd12; wd = 32'h0000_0403;
    tick();
    idle_inputs();
    total_cnt++;
    if (rd !== 32'h0000_0401) $display("FAIL prio_exl_clr: got %h expected %h", rd, 32'h0000_0401);
    else pass_cnt++;
    exl_set = 1'b1; epc_in = 32'h0000_5000; we = 1'b1; wd = 32'h0000_0801;
    tick();
    idle_inputs();
    total_cnt++;
    if (rd !== 32'h0000_0803) $display("FAIL prio_sr_with_entry: got %h expected %h", rd, 32'h0000_0803);
    else pass_cnt++;
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
  endtask

  task automatic test_ext_pin();
    logic [7:0] seen;
    hw_int = 6'h00;
    we = 1'b1; sel = 5'd12; wd = 32'h0000_1001;
    tick();
    we = 1'b0;
    repeat (3) tick();
    hw_int = 6'h04;
    tick();
    hw_int = 6'h00;
    seen = 8'h00;
    for (int i = 0; i < 6; i++) begin
      seen[i] = int_req;
      total_cnt++;
      if (int_req !== exp_req()) $display("FAIL ext_pin_cycle%0d: got %b expected %b", i, int_req, exp_req());
      else pass_cnt++;
      tick();
    end
    // Absolute timing: edges 0,1 low; edge 2 high; then level vs. latch.
`ifdef INT_CTRL_EDGE_LATCH_EN
    total_cnt++;
    if (seen[5:0] !== 6'b111100) $display("FAIL ext_pin_shape: got %b expected %b", seen[5:0], 6'b111100);
    else pass_cnt++;
`else
    total_cnt++;
    if (seen[5:0] !== 6'b000100) $display("FAIL ext_pin_shape: got %b expected %b", seen[5:0], 6'b000100);
    else pass_cnt++;
`endif
    we = 1'b1; sel = 5'd13; wd = 32'h0000_0000;
    tick();
    we = 1'b0;
    total_cnt++;
    if (int_req !== 1'b0) $display("FAIL ext_pin_cleared: got %b expected 0", int_req);
    else pass_cnt++;
    total_cnt++;
    if (rd !== exp_rd(sel)) $display("FAIL ext_pin_cause: got %h expected %h", rd, exp_rd(sel));
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) hw_int = 6'($urandom_range(0, 63));
      exl_set = ($urandom_range(0, 9) == 0);
      exl_clr = ($urandom_range(0, 7) == 0);
      we      = ($urandom_range(0, 2) == 0);
      sel     = 5'($urandom_range(10, 16));
      wd      = $urandom;
      if ($urandom_range(0, 1) == 0) wd[1] = 1'b0;
      epc_in  = $urandom;
      bd_in   = 1'($urandom_range(0, 1));
      tick();
      total_cnt++;
      if (int_req !== exp_req()) $display("FAIL rand_int_req it=%0d: got %b expected %b", i, int_req, exp_req());
      else pass_cnt++;
      total_cnt++;
      if (epc_out !== m_epc) $display("FAIL rand_epc it=%0d: got %h expected %h", i, epc_out, m_epc);
      else pass_cnt++;
      total_cnt++;
      if (rd !== exp_rd(sel)) $display("FAIL rand_rd it=%0d sel=%0d: got %h expected %h", i, sel, rd, exp_rd(sel));
      else pass_cnt++;
    end
    idle_inputs();
    hw_int = 6'h00;
    repeat (4) tick();
  endtask

  task automatic test_async_reset();
    we = 1'b1; sel = 5'd12; wd = 32'h0000_0401; hw_int = 6'h01;
    tick();
    we = 1'b0;
    exl_set = 1'b1; epc_in = 32'h0000_3014;
    tick();
    exl_set = 1'b0;
    total_cnt++;
    if (epc_out !== 32'h0000_3014) $display("FAIL areset_pre_epc: got %h expected %h", epc_out, 32'h0000_3014);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if (int_req !== 1'b0) $display("FAIL areset_int_req: got %b expected 0", int_req);
    else pass_cnt++;
    for (int s = 12; s <= 15; s++) begin
      sel = 5'(s);
      #1;
      total_cnt++;
      if (rd !== ((s == 15) ? PRID : 32'h0)) $display("FAIL areset_rd sel=%0d: got %h expected %h", s, rd, (s == 15) ? PRID : 32'h0);
      else pass_cnt++;
    end
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_timer();
    test_entry_eret();
    test_priority();
    test_ext_pin();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
